// File: rtl/isa_bus_master_pkg.sv
// Shared encodings for the ISA bus master: request command codes and FSM states.
package isa_bus_master_pkg;

  localparam logic [1:0] CMD_MEMR = 2'b00;
  localparam logic [1:0] CMD_MEMW = 2'b01;
  localparam logic [1:0] CMD_IOR  = 2'b10;
  localparam logic [1:0] CMD_IOW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_STRB = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Writes are the odd command codes (memw, iow).
  function automatic logic is_write(input logic [1:0] cmd);
    return cmd[0];
  endfunction

endpackage

// File: rtl/isa_bus_master.sv
// ISA bus master: one request at a time becomes an ADDR / STRB / HOLD bus cycle
// with registered strobes, a minimum strobe width and a bus_rdy timeout.
module isa_bus_master
  import isa_bus_master_pkg::*;
#(
  parameter int STROBE_MIN = 3,
  parameter int WAIT_MAX   = 64
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [19:0] bus_a,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_aen,
  input  logic [7:0]  bus_din,
  input  logic        bus_rdy,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(WAIT_MAX);

  state_t          r_state;
  logic [1:0]      r_cmd;
  logic [CW-1:0]   r_cnt;
  logic [19:0]     r_bus_a;
  logic [7:0]      r_bus_d_out;
  logic            r_bus_d_oe;
  logic            r_memr_l, r_memw_l, r_ior_l, r_iow_l;
  logic            r_rsp_valid, r_rsp_timeout;
  logic [7:0]      r_rsp_rdata;

  logic            w_rdy_done;
  logic            w_tmo;

  // Handshake: a request transfers on any rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so request inputs are ignored mid-transaction.
  assign req_ready = (r_state == ST_IDLE);

  // bus_rdy only counts once the minimum strobe width has elapsed.
  assign w_rdy_done = (int'(r_cnt) >= STROBE_MIN - 1) && bus_rdy;
  assign w_tmo      = (int'(r_cnt) == WAIT_MAX - 1);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state       <= ST_IDLE;
      r_cmd         <= CMD_MEMR;
      r_cnt         <= '0;
      r_bus_a       <= '0;
      r_bus_d_out   <= '0;
      r_bus_d_oe    <= 1'b0;
      r_memr_l      <= 1'b1;
      r_memw_l      <= 1'b1;
      r_ior_l       <= 1'b1;
      r_iow_l       <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cmd       <= req_cmd;
            r_bus_a     <= req_addr;
            r_bus_d_out <= req_wdata;
            r_bus_d_oe  <= is_write(req_cmd);
            r_state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          r_cnt    <= '0;
          r_memr_l <= (r_cmd != CMD_MEMR);
          r_memw_l <= (r_cmd != CMD_MEMW);
          r_ior_l  <= (r_cmd != CMD_IOR);
          r_iow_l  <= (r_cmd != CMD_IOW);
          r_state  <= ST_STRB;
        end
        ST_STRB: begin
          if (w_rdy_done || w_tmo) begin
            r_memr_l      <= 1'b1;
            r_memw_l      <= 1'b1;
            r_ior_l       <= 1'b1;
            r_iow_l       <= 1'b1;
            r_rsp_valid   <= 1'b1;
            // A responder that becomes ready on the last allowed cycle still wins.
            r_rsp_timeout <= !w_rdy_done;
            if (!is_write(r_cmd)) begin
              r_rsp_rdata <= w_rdy_done ? bus_din : 8'hFF;
            end
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          r_bus_d_oe <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign bus_a       = r_bus_a;
  assign bus_d_out   = r_bus_d_out;
  assign bus_d_oe    = r_bus_d_oe;
  assign bus_memr_l  = r_memr_l;
  assign bus_memw_l  = r_memw_l;
  assign bus_ior_l   = r_ior_l;
  assign bus_iow_l   = r_iow_l;
  assign bus_aen     = 1'b0;
  assign dbg_state   = r_state;

endmodule
